// File: rtl/mux_lut_gate_array_pkg.sv
// Shared constants for the mux-built configurable gate array:
// truth-table encodings (bit index {a,b}) and output buffer sizing.
package mux_lut_gate_array_pkg;

   localparam logic [3:0] TT_AND    = 4'b1000;
   localparam logic [3:0] TT_OR     = 4'b1110;
   localparam logic [3:0] TT_XOR    = 4'b0110;
   localparam logic [3:0] TT_NAND   = 4'b0111;
   localparam logic [3:0] TT_NOR    = 4'b0001;
   localparam logic [3:0] TT_XNOR   = 4'b1001;
   localparam logic [3:0] TT_PASS_A = 4'b1100;
   localparam logic [3:0] TT_NOT_B  = 4'b0101;

   localparam int BUF_DEPTH = 2;
   localparam int PTR_W     = $clog2(BUF_DEPTH);
   localparam int OCC_W     = $clog2(BUF_DEPTH + 1);

   localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(BUF_DEPTH);

endpackage

// File: rtl/mux_lut_gate_array_mux2.sv
// Single-bit 2:1 multiplexer, the building block of each per-bit lookup tree.
module mux2 (
   input  logic d0,
   input  logic d1,
   input  logic sel,
   output logic y
);

   assign y = sel ? d1 : d0;

endmodule

// File: rtl/mux_lut_gate_array.sv
// WIDTH-bit array of runtime-configurable 2-input gates feeding a 2-entry
// valid/ready output buffer, with a completed-operation counter.
module mux_lut_gate_array
   import mux_lut_gate_array_pkg::*;
#(
   parameter int         WIDTH  = 8,
   parameter int         CNT_W  = 16,
   parameter logic [3:0] RST_TT = 4'b1000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cfg_we,
   input  logic [3:0]       cfg_tt,
   output logic [3:0]       tt,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_y,
   output logic [CNT_W-1:0] op_count
);

   logic [3:0]       r_tt;
   logic [WIDTH-1:0] r_mem [BUF_DEPTH];
   logic [PTR_W-1:0] r_wrPtr;
   logic [PTR_W-1:0] r_rdPtr;
   logic [OCC_W-1:0] r_occ;
   logic             r_inReady;
   logic [CNT_W-1:0] r_opCount;

   logic [WIDTH-1:0] w_y;
   logic             w_push;
   logic             w_pop;
   logic             w_outValid;
   logic [OCC_W-1:0] w_occNext;

   // Level 1 picks the b-column of each a-row, level 2 picks the row by a.
   for (genvar i = 0; i < WIDTH; i++) begin : gBit
      logic w_rowA0;
      logic w_rowA1;

      mux2 uLvl1Lo (
         .d0  (r_tt[0]),
         .d1  (r_tt[1]),
         .sel (in_b[i]),
         .y   (w_rowA0)
      );

      mux2 uLvl1Hi (
         .d0  (r_tt[2]),
         .d1  (r_tt[3]),
         .sel (in_b[i]),
         .y   (w_rowA1)
      );

      mux2 uLvl2 (
         .d0  (w_rowA0),
         .d1  (w_rowA1),
         .sel (in_a[i]),
         .y   (w_y[i])
      );
   end

   assign w_outValid = (r_occ != '0);
   assign w_push     = in_valid & r_inReady;
   assign w_pop      = w_outValid & out_ready;

   always_comb begin
      w_occNext = r_occ;
      if (w_push && !w_pop) begin
         w_occNext = r_occ + 1'b1;
      end else if (!w_push && w_pop) begin
         w_occNext = r_occ - 1'b1;
      end
   end

   // in_ready is registered from the next occupancy so it never sees out_ready combinationally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_occ     <= '0;
         r_inReady <= 1'b1;
         r_wrPtr   <= '0;
         r_rdPtr   <= '0;
         for (int i = 0; i < BUF_DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else begin
         r_occ     <= w_occNext;
         r_inReady <= (w_occNext < OCC_FULL);
         if (w_push) begin
            r_mem[r_wrPtr] <= w_y;
            r_wrPtr        <= r_wrPtr + 1'b1;
         end
         if (w_pop) begin
            r_rdPtr <= r_rdPtr + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tt      <= RST_TT;
         r_opCount <= '0;
      end else begin
         if (cfg_we) begin
            r_tt <= cfg_tt;
         end
         if (w_pop) begin
            r_opCount <= r_opCount + 1'b1;
         end
      end
   end

   assign tt        = r_tt;
   assign in_ready  = r_inReady;
   assign out_valid = w_outValid;
   assign out_y     = r_mem[r_rdPtr];
   assign op_count  = r_opCount;

endmodule
